// File: rtl/execute_stage_pkg.sv
// Shared widths, alu_op bit indices, the Decode-to-Execute bundle layout
// and the divider state encoding for the Execute stage.
package execute_stage_pkg;

  localparam int DE_BUS_WID     = 155;
  localparam int EM_BUS_WID     = 71;
  localparam int ED_FOR_BUS_WID = 38;
  localparam int ALU_OP_WID     = 19;

  // One-hot alu_op bit positions
  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_MOD   = 16;
  localparam int OP_DIVU  = 17;
  localparam int OP_MODU  = 18;

  // Field order matches DE_BUS from MSB to LSB
  typedef struct packed {
    logic [31:0]           pc;
    logic [ALU_OP_WID-1:0] alu_op;
    logic [31:0]           alu_src1;
    logic [31:0]           alu_src2;
    logic [31:0]           rkd_value;
    logic                  gr_we;
    logic                  mem_we;
    logic [4:0]            dest;
    logic                  res_from_mem;
  } de_bus_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/execute_stage_div_iter.sv
// Radix-2 restoring divider working on operand magnitudes. The first
// iteration happens on the start edge, so the result is ready 32 cycles
// after start. DONE is held while the consumer cannot take the result.
module div_iter
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        hold,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic        busy
);

  div_state_t  state, state_next;
  logic [4:0]  count;
  logic [31:0] rem_q, quo_q, divisor_q, dividend_q;
  logic        neg_quo_q, neg_rem_q, div_zero_q;

  logic        dividend_neg, divisor_neg;
  logic [31:0] dividend_mag, divisor_mag;
  logic [31:0] rem_in, quo_in, den;
  logic [32:0] shifted, diff;
  logic [31:0] rem_out, quo_out;

  assign dividend_neg = signed_op && dividend[31];
  assign divisor_neg  = signed_op && divisor[31];
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg ? -divisor : divisor;

  // One shift-subtract step; from IDLE it starts on the fresh operands
  always_comb begin
    if (state == DIV_IDLE) begin
      rem_in = '0;
      quo_in = dividend_mag;
      den    = divisor_mag;
    end else begin
      rem_in = rem_q;
      quo_in = quo_q;
      den    = divisor_q;
    end
    shifted = {rem_in, quo_in[31]};
    diff    = shifted - {1'b0, den};
    quo_out = {quo_in[30:0], 1'b0};
    rem_out = shifted[31:0];
    if (!diff[32]) begin
      rem_out    = diff[31:0];
      quo_out[0] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Next state: 32 iterations, then DONE until the result is taken
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_BUSY;
      DIV_BUSY: if (count == 5'd31) state_next = DIV_DONE;
      DIV_DONE: if (!hold) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Partial remainder/quotient, iteration counter and sign bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (state == DIV_IDLE) begin
      if (start) begin
        rem_q      <= rem_out;
        quo_q      <= quo_out;
        divisor_q  <= divisor_mag;
        dividend_q <= dividend;
        neg_quo_q  <= dividend_neg ^ divisor_neg;
        neg_rem_q  <= dividend_neg;
        div_zero_q <= (divisor == 32'd0);
        count      <= 5'd1;
      end
    end else if (state == DIV_BUSY) begin
      rem_q <= rem_out;
      quo_q <= quo_out;
      count <= count + 5'd1;
    end
  end

  assign quotient  = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
  assign remainder = div_zero_q ? dividend_q : (neg_rem_q ? -rem_q : rem_q);
  assign done      = (state == DIV_DONE);
  assign busy      = (state == DIV_BUSY);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: latches the Decode bundle, computes ALU/multiply results
// in one cycle and divides iteratively, issues the data SRAM request,
// forwards to Decode and hands the result to Memory.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      DE_valid,
  input  logic [DE_BUS_WID-1:0]     DE_BUS,
  output logic                      E_allowin,
  input  logic                      M_allowin,
  output logic                      EM_valid,
  output logic [EM_BUS_WID-1:0]     EM_BUS,
  output logic [ED_FOR_BUS_WID-1:0] ED_for_BUS,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata
);

  de_bus_t     de_q;
  logic        e_valid, e_ready_go, div_first;
  logic        is_div, div_start, div_done, div_busy, div_signed;
  logic [31:0] quotient, remainder, alu_result, src1, src2;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic        not_ready_e;
  logic [4:0]  dest_e;

  assign src1       = de_q.alu_src1;
  assign src2       = de_q.alu_src2;
  assign is_div     = |de_q.alu_op[OP_MODU:OP_DIV];
  assign div_signed = de_q.alu_op[OP_DIV] | de_q.alu_op[OP_MOD];
  assign e_ready_go = !is_div || div_done;
  assign E_allowin  = !e_valid || (e_ready_go && M_allowin);
  assign EM_valid   = e_valid && e_ready_go;
  assign div_start  = e_valid && is_div && div_first;

  // Pipeline register; div_first marks the first occupancy cycle of a divide
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_valid   <= 1'b0;
      de_q      <= '0;
      div_first <= 1'b0;
    end else begin
      if (E_allowin) e_valid <= DE_valid;
      if (DE_valid && E_allowin) begin
        de_q      <= de_bus_t'(DE_BUS);
        div_first <= 1'b1;
      end else if (div_start) begin
        div_first <= 1'b0;
      end
    end
  end

  div_iter u_div_iter (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_start),
    .hold      (!M_allowin),
    .signed_op (div_signed),
    .dividend  (src1),
    .divisor   (src2),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (div_done),
    .busy      (div_busy)
  );

  // Only mulh treats operands as signed; the low word is sign-agnostic
  assign mul_a    = {{32{de_q.alu_op[OP_MULH] & src1[31]}}, src1};
  assign mul_b    = {{32{de_q.alu_op[OP_MULH] & src2[31]}}, src2};
  assign mul_prod = mul_a * mul_b;

  // Result select over the one-hot operation
  always_comb begin
    alu_result = '0;
    if (de_q.alu_op[OP_ADD])        alu_result = src1 + src2;
    else if (de_q.alu_op[OP_SUB])   alu_result = src1 - src2;
    else if (de_q.alu_op[OP_SLT])   alu_result = {31'b0, $signed(src1) < $signed(src2)};
    else if (de_q.alu_op[OP_SLTU])  alu_result = {31'b0, src1 < src2};
    else if (de_q.alu_op[OP_AND])   alu_result = src1 & src2;
    else if (de_q.alu_op[OP_NOR])   alu_result = ~(src1 | src2);
    else if (de_q.alu_op[OP_OR])    alu_result = src1 | src2;
    else if (de_q.alu_op[OP_XOR])   alu_result = src1 ^ src2;
    else if (de_q.alu_op[OP_SLL])   alu_result = src1 << src2[4:0];
    else if (de_q.alu_op[OP_SRL])   alu_result = src1 >> src2[4:0];
    else if (de_q.alu_op[OP_SRA])   alu_result = $unsigned($signed(src1) >>> src2[4:0]);
    else if (de_q.alu_op[OP_LUI])   alu_result = src2;
    else if (de_q.alu_op[OP_MUL])   alu_result = mul_prod[31:0];
    else if (de_q.alu_op[OP_MULH] || de_q.alu_op[OP_MULHU]) alu_result = mul_prod[63:32];
    else if (de_q.alu_op[OP_DIV] || de_q.alu_op[OP_DIVU])   alu_result = quotient;
    else if (de_q.alu_op[OP_MOD] || de_q.alu_op[OP_MODU])   alu_result = remainder;
  end

  // A divide is unfinished while in its start cycle or iterating; this
  // is the same as "not done" for every reachable divider state.
  assign not_ready_e = e_valid && (de_q.res_from_mem || (is_div && (div_first || div_busy)));
  assign dest_e      = (e_valid && de_q.gr_we) ? de_q.dest : 5'd0;
  assign ED_for_BUS  = {not_ready_e, dest_e, alu_result};

  assign EM_BUS = {de_q.pc, de_q.gr_we, de_q.dest, de_q.res_from_mem, alu_result};

  assign data_sram_en    = e_valid && (de_q.res_from_mem || de_q.mem_we) && M_allowin;
  assign data_sram_we    = {4{e_valid && de_q.mem_we && M_allowin}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = de_q.rkd_value;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU/multiply ops, divides,
// store under stall, back-to-back divides with a stalled DONE, reset mid-divide.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic         DE_valid;
  logic [154:0] DE_BUS;
  logic         E_allowin;
  logic         M_allowin;
  logic         EM_valid;
  logic [70:0]  EM_BUS;
  logic [37:0]  ED_for_BUS;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int vectors = 0;
  int miscompares = 0;

  execute_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .DE_valid        (DE_valid),
    .DE_BUS          (DE_BUS),
    .E_allowin       (E_allowin),
    .M_allowin       (M_allowin),
    .EM_valid        (EM_valid),
    .EM_BUS          (EM_BUS),
    .ED_for_BUS      (ED_for_BUS),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [154:0] make_de(input logic [31:0] pc, input int op,
                                           input logic [31:0] s1, input logic [31:0] s2,
                                           input logic [31:0] rkd, input logic gr_we,
                                           input logic mem_we, input logic [4:0] dest,
                                           input logic rfm);
    logic [18:0] opv;
    opv = '0;
    opv[op] = 1'b1;
    return {pc, opv, s1, s2, rkd, gr_we, mem_we, dest, rfm};
  endfunction

  // Present a bundle until captured; returns at cycle 1 of its E occupancy
  task automatic issue(input logic [154:0] bus);
    int waited = 0;
    @(negedge clk);
    DE_valid = 1'b1;
    DE_BUS   = bus;
    #1;
    while (!E_allowin && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (E_allowin !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL issue_timeout E_allowin got %b want 1", E_allowin);
    end
    @(negedge clk);
    DE_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; DE_valid = 1'b0; DE_BUS = '0; M_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (EM_valid !== 1'b0 || EM_BUS !== 71'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_em valid=%b bus=%h want 0/0", EM_valid, EM_BUS);
    end
    vectors++;
    if (ED_for_BUS !== 38'd0 || E_allowin !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_fwd ed=%h allowin=%b want 0/1", ED_for_BUS, E_allowin);
    end
    vectors++;
    if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0 || data_sram_addr !== 32'h0 || data_sram_wdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_sram en=%b we=%h addr=%h wdata=%h want all 0",
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_add();
    issue(make_de(32'h1000, OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 5'd5, 1'b0));
    vectors++;
    if (EM_valid !== 1'b1 || EM_BUS !== {32'h1000, 1'b1, 5'd5, 1'b0, 32'h8000_0000}) begin
      miscompares++;
      $display("[TB] FAIL add_em valid=%b bus=%h want 1/%h", EM_valid, EM_BUS,
               {32'h1000, 1'b1, 5'd5, 1'b0, 32'h8000_0000});
    end
    vectors++;
    if (ED_for_BUS !== {1'b0, 5'd5, 32'h8000_0000} || data_sram_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_fwd ed=%h en=%b want %h/0", ED_for_BUS, data_sram_en,
               {1'b0, 5'd5, 32'h8000_0000});
    end
    @(negedge clk);
    #1;
    vectors++;
    if (EM_valid !== 1'b0 || ED_for_BUS[36:32] !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL add_drain valid=%b dest=%0d want 0/0", EM_valid, ED_for_BUS[36:32]);
    end
  endtask

  task automatic test_alu_ops();
    int          ops[16]  = '{OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR, OP_SLL,
                             OP_SRL, OP_SRA, OP_LUI, OP_MUL, OP_MULH, OP_MULHU, OP_MULH, OP_MUL};
    logic [31:0] a[16]    = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h0,
                             32'h0000_FFFF, 32'hFFFF_0000, 32'h1, 32'h8000_0000, 32'h8000_0000,
                             32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFFF};
    logic [31:0] b[16]    = '{32'd7, 32'h1, 32'h1, 32'hFF00_FF00, 32'h0, 32'h00FF_0000,
                             32'h0FF0_0FF0, 32'h23, 32'h4, 32'h4, 32'h1234_5000, 32'h2,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF};
    logic [31:0] want[16] = '{32'hFFFF_FFFE, 32'h1, 32'h0, 32'hF000_F000, 32'hFFFF_FFFF,
                             32'h00FF_FFFF, 32'hF00F_0FF0, 32'h8, 32'h0800_0000, 32'hF800_0000,
                             32'h1234_5000, 32'h2468_ACF0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'h1};
    for (int i = 0; i < 16; i++) begin
      issue(make_de(32'h3000 + 32'(i * 4), ops[i], a[i], b[i], 32'h0, 1'b1, 1'b0, 5'd1, 1'b0));
      vectors++;
      if (EM_valid !== 1'b1 || EM_BUS[31:0] !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL alu_op%0d valid=%b result=%h want 1/%h", ops[i], EM_valid,
                 EM_BUS[31:0], want[i]);
      end
    end
  endtask

  task automatic run_div(input string name, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
    int bad_cycle = 0;
    issue(make_de(32'h4000, op, a, b, 32'h0, 1'b1, 1'b0, 5'd3, 1'b0));
    for (int k = 1; k <= 32; k++) begin
      if ((ED_for_BUS[37] !== 1'b1 || E_allowin !== 1'b0 || EM_valid !== 1'b0 ||
           ED_for_BUS[36:32] !== 5'd3) && bad_cycle == 0)
        bad_cycle = k;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (bad_cycle != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_stall first bad cycle got %0d want none", name, bad_cycle);
    end
    vectors++;
    if (EM_valid !== 1'b1 || ED_for_BUS[37] !== 1'b0 || E_allowin !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_done valid=%b not_ready=%b allowin=%b want 1/0/1", name,
               EM_valid, ED_for_BUS[37], E_allowin);
    end
    vectors++;
    if (EM_BUS[31:0] !== want) begin
      miscompares++;
      $display("[TB] FAIL %s_result got %h want %h", name, EM_BUS[31:0], want);
    end
  endtask

  task automatic test_divide();
    run_div("divw_neg7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    run_div("modw_neg7_2",   OP_MOD,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    run_div("divwu_5_0",     OP_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF);
    run_div("modwu_5_0",     OP_MODU, 32'd5,         32'd0,        32'd5);
    run_div("divw_min_m1",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("modw_min_m1",   OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_div("divw_m20_m3",   OP_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6);
    run_div("modw_m20_m3",   OP_MOD,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    run_div("divw_m5_0",     OP_DIV,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF);
    run_div("modw_m5_0",     OP_MOD,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB);
    run_div("divwu_max_7",   OP_DIVU, 32'hFFFF_FFFF, 32'd7,        32'h2492_4924);
    run_div("modwu_max_7",   OP_MODU, 32'hFFFF_FFFF, 32'd7,        32'd3);
  endtask

  task automatic test_store_stall();
    int we_cycles = 0;
    int bad_cycle = 0;
    @(negedge clk);
    M_allowin = 1'b0;
    DE_valid  = 1'b1;
    DE_BUS    = make_de(32'h2000, OP_ADD, 32'h18, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    DE_BUS = make_de(32'h2004, OP_ADD, 32'd3, 32'd4, 32'h0, 1'b1, 1'b0, 5'd9, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (data_sram_we == 4'hF) we_cycles++;
      if ((data_sram_we !== 4'h0 || data_sram_en !== 1'b0 || data_sram_addr !== 32'h1C ||
           E_allowin !== 1'b0 || EM_valid !== 1'b1) && bad_cycle == 0)
        bad_cycle = k;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (bad_cycle != 0) begin
      miscompares++;
      $display("[TB] FAIL store_stall first bad cycle got %0d want none", bad_cycle);
    end
    M_allowin = 1'b1;
    #1;
    if (data_sram_we == 4'hF) we_cycles++;
    vectors++;
    if (data_sram_we !== 4'hF || data_sram_en !== 1'b1 || data_sram_addr !== 32'h1C ||
        data_sram_wdata !== 32'hDEAD_BEEF || E_allowin !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL store_issue we=%h en=%b addr=%h wdata=%h allowin=%b want f/1/1c/deadbeef/1",
               data_sram_we, data_sram_en, data_sram_addr, data_sram_wdata, E_allowin);
    end
    @(negedge clk);
    #1;
    DE_valid = 1'b0;
    if (data_sram_we == 4'hF) we_cycles++;
    vectors++;
    if (EM_valid !== 1'b1 || EM_BUS[31:0] !== 32'd7 || EM_BUS[70:39] !== 32'h2004 ||
        ED_for_BUS[36:32] !== 5'd9) begin
      miscompares++;
      $display("[TB] FAIL store_next valid=%b result=%h pc=%h dest=%0d want 1/7/2004/9",
               EM_valid, EM_BUS[31:0], EM_BUS[70:39], ED_for_BUS[36:32]);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      if (data_sram_we == 4'hF) we_cycles++;
    end
    vectors++;
    if (we_cycles !== 1) begin
      miscompares++;
      $display("[TB] FAIL store_once we cycles got %0d want 1", we_cycles);
    end
  endtask

  task automatic test_back_to_back();
    int bad_cycle = 0;
    @(negedge clk);
    M_allowin = 1'b1;
    DE_valid  = 1'b1;
    DE_BUS    = make_de(32'h5000, OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0, 5'd6, 1'b0);
    @(negedge clk);
    #1;
    DE_BUS    = make_de(32'h5004, OP_MODU, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0, 5'd7, 1'b0);
    M_allowin = 1'b0;
    repeat (32) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (EM_valid !== 1'b1 || E_allowin !== 1'b0 || EM_BUS[31:0] !== 32'd14 || EM_BUS[70:39] !== 32'h5000) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done valid=%b allowin=%b result=%h pc=%h want 1/0/e/5000",
               EM_valid, E_allowin, EM_BUS[31:0], EM_BUS[70:39]);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      if ((EM_valid !== 1'b1 || EM_BUS[31:0] !== 32'd14 || ED_for_BUS[37] !== 1'b0) && bad_cycle == 0)
        bad_cycle = k;
    end
    vectors++;
    if (bad_cycle != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_hold first bad cycle got %0d want none", bad_cycle);
    end
    M_allowin = 1'b1;
    #1;
    vectors++;
    if (E_allowin !== 1'b1 || EM_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_release allowin=%b valid=%b want 1/1", E_allowin, EM_valid);
    end
    @(negedge clk);
    #1;
    DE_valid = 1'b0;
    vectors++;
    if (ED_for_BUS[37] !== 1'b1 || EM_valid !== 1'b0 || ED_for_BUS[36:32] !== 5'd7) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_start not_ready=%b valid=%b dest=%0d want 1/0/7",
               ED_for_BUS[37], EM_valid, ED_for_BUS[36:32]);
    end
    repeat (32) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (EM_valid !== 1'b1 || EM_BUS[31:0] !== 32'd2 || EM_BUS[70:39] !== 32'h5004) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_done valid=%b result=%h pc=%h want 1/2/5004",
               EM_valid, EM_BUS[31:0], EM_BUS[70:39]);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen = 0;
    issue(make_de(32'h6000, OP_DIV, 32'd100, 32'd3, 32'h0, 1'b1, 1'b0, 5'd8, 1'b0));
    repeat (9) begin
      @(negedge clk);
      #1;
    end
    rstn = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    vectors++;
    if (EM_valid !== 1'b0 || E_allowin !== 1'b1 || data_sram_en !== 1'b0 || ED_for_BUS !== 38'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_div valid=%b allowin=%b en=%b ed=%h want 0/1/0/0",
               EM_valid, E_allowin, data_sram_en, ED_for_BUS);
    end
    repeat (40) begin
      @(negedge clk);
      #1;
      if (EM_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_div_quiet EM_valid cycles got %0d want 0", seen);
    end
    issue(make_de(32'h6100, OP_ADD, 32'd2, 32'd3, 32'h0, 1'b1, 1'b0, 5'd4, 1'b0));
    vectors++;
    if (EM_valid !== 1'b1 || EM_BUS[31:0] !== 32'd5 || ED_for_BUS[36:32] !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL rst_then_add valid=%b result=%h dest=%0d want 1/5/4",
               EM_valid, EM_BUS[31:0], ED_for_BUS[36:32]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_divide();
    test_store_stall();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit reached got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
